// File: rtl/multi_axis_position_tracker_if.sv
// Bus bundle for the multi-axis step/dir position tracker: driver inputs,
// load/limit configuration and per-axis status outputs.
interface multi_axis_position_tracker_if #(
   parameter int NUM_AXES  = 5,
   parameter int POS_WIDTH = 32
);
   logic [NUM_AXES-1:0]           step;
   logic [NUM_AXES-1:0]           dir;
   logic [NUM_AXES-1:0]           enable;
   logic [NUM_AXES-1:0]           inversion;
   logic [NUM_AXES-1:0]           set_new;
   logic [NUM_AXES*POS_WIDTH-1:0] new_pos;
   logic [NUM_AXES*POS_WIDTH-1:0] soft_min;
   logic [NUM_AXES*POS_WIDTH-1:0] soft_max;
   logic [NUM_AXES-1:0]           limit_en;
   logic                          clear_flags;
   logic [NUM_AXES*POS_WIDTH-1:0] pos;
   logic [NUM_AXES-1:0]           moving;
   logic [NUM_AXES-1:0]           at_min;
   logic [NUM_AXES-1:0]           at_max;
   logic [NUM_AXES-1:0]           limit_hit;
   logic [NUM_AXES-1:0]           glitch;

   modport master (
      output step, dir, enable, inversion, set_new, new_pos,
             soft_min, soft_max, limit_en, clear_flags,
      input  pos, moving, at_min, at_max, limit_hit, glitch
   );

   modport slave (
      input  step, dir, enable, inversion, set_new, new_pos,
             soft_min, soft_max, limit_en, clear_flags,
      output pos, moving, at_min, at_max, limit_hit, glitch
   );
endinterface

// File: rtl/multi_axis_position_tracker.sv
// Per-axis step/dir position tracker with pulse-width qualification,
// soft limits, saturation, sticky flags and a motion idle timer.
//
// state    | meaning
// IDLE     | step low (or axis disabled), waiting for a rising step
// HIGH_CNT | step high, counting synchronised high cycles toward MIN_PULSE
// COUNTED  | step committed, waiting for step to return low
module multi_axis_position_tracker #(
   parameter int NUM_AXES      = 5,
   parameter int POS_WIDTH     = 32,
   parameter int SYNC_STAGES   = 2,
   parameter int MIN_PULSE     = 2,
   parameter int EN_ACTIVE_LOW = 1,
   parameter int IDLE_TIMEOUT  = 1000
) (
   input logic                        clk,
   input logic                        reset,
   multi_axis_position_tracker_if.slave bus
);

   localparam int CW = (MIN_PULSE > 1) ? $clog2(MIN_PULSE + 1) : 1;
   localparam int IW = $clog2(IDLE_TIMEOUT + 1);
   localparam logic signed [POS_WIDTH-1:0] POS_MAX = {1'b0, {(POS_WIDTH-1){1'b1}}};
   localparam logic signed [POS_WIDTH-1:0] POS_MIN = {1'b1, {(POS_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, HIGH_CNT, COUNTED} state_t;

   logic [NUM_AXES-1:0] step_q [SYNC_STAGES];
   logic [NUM_AXES-1:0] dir_q  [SYNC_STAGES];
   logic [NUM_AXES-1:0] en_q   [SYNC_STAGES];
   logic [NUM_AXES-1:0] step_s, dir_s, en_s, axis_en;

   state_t  state [NUM_AXES];
   state_t  nstate [NUM_AXES];
   logic [CW-1:0] cnt [NUM_AXES];
   logic [CW-1:0] ncnt [NUM_AXES];
   logic [NUM_AXES-1:0] commit, glitch_ev;

   logic signed [POS_WIDTH-1:0] pos_r   [NUM_AXES];
   logic signed [POS_WIDTH-1:0] pos_nxt [NUM_AXES];
   logic signed [POS_WIDTH-1:0] smin    [NUM_AXES];
   logic signed [POS_WIDTH-1:0] smax    [NUM_AXES];
   logic signed [POS_WIDTH-1:0] newp    [NUM_AXES];
   logic [NUM_AXES-1:0] up, blocked, lim_ev;

   logic [NUM_AXES-1:0] moving_r, lim_hit_r, glitch_r;
   logic [IW-1:0]       idle_cnt [NUM_AXES];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            step_q[s] <= '0;
            dir_q[s]  <= '0;
            en_q[s]   <= '0;
         end
      end else begin
         step_q[0] <= bus.step;
         dir_q[0]  <= bus.dir;
         en_q[0]   <= bus.enable;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            step_q[s] <= step_q[s-1];
            dir_q[s]  <= dir_q[s-1];
            en_q[s]   <= en_q[s-1];
         end
      end
   end

   assign step_s  = step_q[SYNC_STAGES-1];
   assign dir_s   = dir_q[SYNC_STAGES-1];
   assign en_s    = en_q[SYNC_STAGES-1];
   assign axis_en = (EN_ACTIVE_LOW != 0) ? ~en_s : en_s;

   for (genvar g = 0; g < NUM_AXES; g++) begin : g_slice
      assign smin[g] = bus.soft_min[g*POS_WIDTH +: POS_WIDTH];
      assign smax[g] = bus.soft_max[g*POS_WIDTH +: POS_WIDTH];
      assign newp[g] = bus.new_pos[g*POS_WIDTH +: POS_WIDTH];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_AXES; i++) begin
            state[i] <= IDLE;
            cnt[i]   <= '0;
         end
      end else begin
         state <= nstate;
         cnt   <= ncnt;
      end
   end

   always_comb begin
      commit    = '0;
      glitch_ev = '0;
      for (int i = 0; i < NUM_AXES; i++) begin
         nstate[i] = state[i];
         ncnt[i]   = cnt[i];
         if (!axis_en[i]) begin
            nstate[i] = IDLE;
            ncnt[i]   = '0;
         end else begin
            case (state[i])
               IDLE: if (step_s[i]) begin
                  if (MIN_PULSE == 1) begin
                     commit[i] = 1'b1;
                     nstate[i] = COUNTED;
                  end else begin
                     nstate[i] = HIGH_CNT;
                     ncnt[i]   = CW'(1);
                  end
               end
               HIGH_CNT: if (step_s[i]) begin
                  if (cnt[i] == CW'(MIN_PULSE - 1)) begin
                     commit[i] = 1'b1;
                     nstate[i] = COUNTED;
                     ncnt[i]   = '0;
                  end else begin
                     ncnt[i] = cnt[i] + CW'(1);
                  end
               end else begin
                  glitch_ev[i] = 1'b1;
                  nstate[i]    = IDLE;
                  ncnt[i]      = '0;
               end
               COUNTED: if (!step_s[i]) nstate[i] = IDLE;
               default: nstate[i] = IDLE;
            endcase
         end
      end
   end

   // A load always beats a coincident commit; the step is simply lost.
   always_comb begin
      up      = '0;
      blocked = '0;
      lim_ev  = '0;
      for (int i = 0; i < NUM_AXES; i++) begin
         pos_nxt[i] = pos_r[i];
         up[i]      = dir_s[i] ^ bus.inversion[i];
         if (bus.limit_en[i])
            blocked[i] = up[i] ? (pos_r[i] >= smax[i]) : (pos_r[i] <= smin[i]);
         else
            blocked[i] = up[i] ? (pos_r[i] == POS_MAX) : (pos_r[i] == POS_MIN);
         if (bus.set_new[i]) begin
            pos_nxt[i] = newp[i];
         end else if (commit[i]) begin
            if (blocked[i]) lim_ev[i] = 1'b1;
            else if (up[i]) pos_nxt[i] = pos_r[i] + POS_WIDTH'(1);
            else            pos_nxt[i] = pos_r[i] - POS_WIDTH'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NUM_AXES; i++) begin
            pos_r[i]    <= '0;
            idle_cnt[i] <= '0;
         end
         moving_r  <= '0;
         lim_hit_r <= '0;
         glitch_r  <= '0;
      end else begin
         pos_r     <= pos_nxt;
         lim_hit_r <= lim_ev | (lim_hit_r & ~{NUM_AXES{bus.clear_flags}});
         glitch_r  <= glitch_ev | (glitch_r & ~{NUM_AXES{bus.clear_flags}});
         for (int i = 0; i < NUM_AXES; i++) begin
            if (commit[i] && !bus.set_new[i]) begin
               moving_r[i] <= 1'b1;
               idle_cnt[i] <= IW'(IDLE_TIMEOUT);
            end else if (moving_r[i]) begin
               if (idle_cnt[i] == IW'(1)) begin
                  moving_r[i] <= 1'b0;
                  idle_cnt[i] <= '0;
               end else begin
                  idle_cnt[i] <= idle_cnt[i] - IW'(1);
               end
            end
         end
      end
   end

   always_comb begin
      bus.pos    = '0;
      bus.at_min = '0;
      bus.at_max = '0;
      for (int i = 0; i < NUM_AXES; i++) begin
         bus.pos[i*POS_WIDTH +: POS_WIDTH] = pos_r[i];
         bus.at_min[i] = bus.limit_en[i] && (pos_r[i] == smin[i]);
         bus.at_max[i] = bus.limit_en[i] && (pos_r[i] == smax[i]);
      end
   end

   assign bus.moving    = moving_r;
   assign bus.limit_hit = lim_hit_r;
   assign bus.glitch    = glitch_r;

endmodule
